clk_ratio_det: RTL and testbench
================================

CLK_RATIO_DET -- requirements
Module: clk_ratio_det

Interface
REQ-001 Parameter RATIO_WID, default 8: ratio field width. Period 2^RATIO_WID is encoded as ratio 0.
REQ-002 Parameter LOCK_CNT, default 4: consecutive matching measurements needed for lock; legal range 1..15.
REQ-003 Port i_clk, input, 1: single clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous assert, active-high.
REQ-005 Port meas_clk, input, 1: divided clock under test; asynchronous to the logic; sampled only.
REQ-006 Port en, input, 1: measurement enable; low forces IDLE.
REQ-007 Port exp_ratio, input, RATIO_WID: expected ratio, same encoding as ratio.
REQ-008 Port ratio, output, RATIO_WID: last measured period in i_clk cycles.
REQ-009 Port ratio_vld, output, 1: one-cycle pulse when ratio updates.
REQ-010 Port lock, output, 1: level; measurement stable and equal to exp_ratio.
REQ-011 Port mismatch, output, 1: sticky; a locked measurement differed from exp_ratio.
REQ-012 Port timeout, output, 1: one-cycle pulse; no rising edge within 2^RATIO_WID cycles.

Function
REQ-013 meas_clk passes through a 2-flop synchronizer (s1, s2), then one history flop s3; rise_det = s2 & !s3.
REQ-014 State machine states:
- IDLE
- SYNC: wait for first edge
- MEAS: measuring, not locked
- LOCKED
REQ-015 Transitions:
- IDLE->SYNC when en=1.
- SYNC->MEAS on rise_det.
- MEAS->LOCKED when match count reaches LOCK_CNT.
- LOCKED->MEAS on a measurement != exp_ratio.
- Any state->IDLE when en=0.
- MEAS/LOCKED->SYNC on timeout.
REQ-016 Period counter: RATIO_WID+1 bits.
- Cleared to 0 on every rise_det in SYNC/MEAS/LOCKED.
- Otherwise increments by 1 each cycle.
- Held at 0 in IDLE.
REQ-017 On rise_det in MEAS/LOCKED, the measured period is counter+1. Period 2^RATIO_WID is stored as 0. ratio is registered, and ratio_vld pulses the cycle after rise_det.
REQ-018 The rise_det in SYNC only starts the counter: no ratio_vld, ratio unchanged.
REQ-019 Match counter (4 bits):
- Increments on each measurement equal to exp_ratio.
- Clears on any unequal measurement, and in IDLE/SYNC.
- Saturates at LOCK_CNT.
REQ-020 lock rises in the same cycle as the ratio_vld that completes LOCK_CNT matches. It falls in the same cycle as the ratio_vld carrying an unequal value, or on timeout or en=0.
REQ-021 mismatch sets together with the falling lock in the LOCKED->MEAS case. It stays set until en=0 or rst. Unequal values in MEAS do not set it.
REQ-022 If the counter reaches 2^RATIO_WID without rise_det in MEAS/LOCKED:
- timeout pulses for one cycle.
- lock clears, match counter clears, state goes to SYNC.
- ratio holds its value; no ratio_vld.
REQ-023 If rise_det and the timeout condition occur in the same cycle, rise_det wins: normal measurement, no timeout.
REQ-024 A constant meas_clk (including undivided ratio 1 or a stopped clock) produces timeout repeatedly, once every 2^RATIO_WID cycles, while in SYNC/MEAS/LOCKED. In SYNC, timeout pulses but the state stays SYNC.
REQ-025 en=0 takes effect on the next edge:
- state IDLE.
- ratio, ratio_vld, lock, mismatch, timeout, and both counters all 0.
- Synchronizer flops keep sampling.
REQ-026 A change of exp_ratio takes effect at the next measurement compare; no other side effect.

Reset
REQ-027 rst=1 asynchronously forces:
- state IDLE.
- s1/s2/s3 = 0.
- Both counters 0.
- ratio=0, ratio_vld=0, lock=0, mismatch=0, timeout=0.
REQ-028 After rst deasserts, operation restarts from IDLE. A reset mid-lock needs LOCK_CNT fresh matches to re-lock.

Verification
REQ-029 meas_clk divided by 5 from i_clk, exp_ratio=5, en=1, LOCK_CNT=4 -> ratio=5 with ratio_vld every 5 cycles; lock rises with the 4th ratio_vld; mismatch=0.
REQ-030 Divide by 256, exp_ratio=0 -> ratio=0 every 256 cycles; lock after 4 pulses; no timeout.
REQ-031 Locked at 5, divider switched to 6 -> first ratio_vld shows ratio=6; lock=0 and mismatch=1 in that cycle; mismatch stays 1 until en=0.
REQ-032 meas_clk held at 0 after lock -> timeout pulses 256 cycles after the last rise_det counter clear; lock=0; state SYNC; timeout repeats every 256 cycles.
REQ-033 en dropped mid-measurement while locked -> next cycle all outputs 0. Re-enable -> first ratio_vld one full period after the first detected edge.
REQ-034 rst pulsed asynchronously between clock edges while locked -> outputs 0 immediately without a clock edge; re-lock after 4 matches.

Source files
------------

// File: rtl/clk_ratio_det.sv
// rtl/clk_ratio_det.sv - measures the period of a divided clock and locks to an expected ratio
//
// Ports:
//   i_clk     : reference clock, all logic on its rising edge
//   rst       : asynchronous active-high reset
//   meas_clk  : divided clock under test, asynchronous, sampled only
//   en        : measurement enable, low returns the block to IDLE
//   exp_ratio : expected period in i_clk cycles (2^RATIO_WID encoded as 0)
//   ratio     : last measured period in i_clk cycles (2^RATIO_WID encoded as 0)
//   ratio_vld : one-cycle pulse when ratio updates
//   lock      : LOCK_CNT consecutive measurements equal to exp_ratio
//   mismatch  : sticky, a locked measurement differed from exp_ratio
//   timeout   : one-cycle pulse, no meas_clk rising edge within 2^RATIO_WID cycles
module clk_ratio_det #(
  parameter int RATIO_WID = 8,
  parameter int LOCK_CNT  = 4
) (
  input  logic                 i_clk,
  input  logic                 rst,
  input  logic                 meas_clk,
  input  logic                 en,
  input  logic [RATIO_WID-1:0] exp_ratio,
  output logic [RATIO_WID-1:0] ratio,
  output logic                 ratio_vld,
  output logic                 lock,
  output logic                 mismatch,
  output logic                 timeout
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_MEAS   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

  state_t               state;
  logic                 s1;
  logic                 s2;
  logic                 s3;
  logic [RATIO_WID:0]   per_cnt;
  logic [3:0]           match_cnt;

  logic                 rise_det;
  logic [RATIO_WID-1:0] meas_val;
  logic                 meas_eq;
  logic                 timeout_hit;
  logic [3:0]           match_nxt;

  assign rise_det = s2 & ~s3;

  // Period is counter+1; the truncation naturally maps 2^RATIO_WID to 0.
  assign meas_val = per_cnt[RATIO_WID-1:0] + RATIO_WID'(1);
  assign meas_eq  = (meas_val == exp_ratio);

  // The counter is about to reach 2^RATIO_WID (low bits all ones). Testing
  // only the low bits makes a stopped clock time out again every
  // 2^RATIO_WID cycles as the counter keeps running and wraps.
  assign timeout_hit = (per_cnt[RATIO_WID-1:0] == '1) && !rise_det;

  assign match_nxt = (match_cnt == LOCK_TGT) ? match_cnt : match_cnt + 4'd1;

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      per_cnt   <= '0;
      match_cnt <= '0;
      ratio     <= '0;
      ratio_vld <= 1'b0;
      lock      <= 1'b0;
      mismatch  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      // Synchronizer samples regardless of enable.
      s1        <= meas_clk;
      s2        <= s1;
      s3        <= s2;
      ratio_vld <= 1'b0;
      timeout   <= 1'b0;

      if (!en) begin
        state     <= ST_IDLE;
        per_cnt   <= '0;
        match_cnt <= '0;
        ratio     <= '0;
        lock      <= 1'b0;
        mismatch  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state   <= ST_SYNC;
            per_cnt <= '0;
          end

          // First edge only starts the counter; no measurement yet.
          ST_SYNC: begin
            if (rise_det) begin
              state   <= ST_MEAS;
              per_cnt <= '0;
            end else begin
              per_cnt <= per_cnt + 1'b1;
              if (timeout_hit) begin
                timeout <= 1'b1;
              end
            end
          end

          ST_MEAS, ST_LOCKED: begin
            if (rise_det) begin
              per_cnt   <= '0;
              ratio     <= meas_val;
              ratio_vld <= 1'b1;
              if (meas_eq) begin
                match_cnt <= match_nxt;
                if (match_nxt == LOCK_TGT) begin
                  state <= ST_LOCKED;
                  lock  <= 1'b1;
                end
              end else begin
                match_cnt <= '0;
                lock      <= 1'b0;
                state     <= ST_MEAS;
                if (state == ST_LOCKED) begin
                  mismatch <= 1'b1;
                end
              end
            end else begin
              per_cnt <= per_cnt + 1'b1;
              if (timeout_hit) begin
                timeout   <= 1'b1;
                lock      <= 1'b0;
                match_cnt <= '0;
                state     <= ST_SYNC;
              end
            end
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_ratio_det.sv
// tb/tb_clk_ratio_det.sv - randomized self-checking bench for clk_ratio_det
module tb_clk_ratio_det;

  localparam int PW   = 8;
  localparam int LK   = 4;
  localparam int FULL = 1 << PW;

  logic          i_clk = 1'b0;
  logic          rst;
  logic          meas_clk;
  logic          en;
  logic [PW-1:0] exp_ratio;
  logic [PW-1:0] ratio;
  logic          ratio_vld;
  logic          lock;
  logic          mismatch;
  logic          timeout;

  clk_ratio_det #(.RATIO_WID(PW), .LOCK_CNT(LK)) dut (
    .i_clk     (i_clk),
    .rst       (rst),
    .meas_clk  (meas_clk),
    .en        (en),
    .exp_ratio (exp_ratio),
    .ratio     (ratio),
    .ratio_vld (ratio_vld),
    .lock      (lock),
    .mismatch  (mismatch),
    .timeout   (timeout)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int to_seen  = 0;

  // Divided-clock generator
  int div_n = 0;
  int ph    = 0;

  // Reference model: time-stamp based, period = distance between edges
  bit samp[$];
  int m_phase;     // 0 off, 1 waiting for first edge, 2 measuring
  int m_tstart;    // cycle index at which the current period started
  int m_match;
  int m_ratio;
  int m_vld;
  int m_lock;
  int m_mis;
  int m_to;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_phase  = 0;
    m_tstart = 0;
    m_match  = 0;
    m_ratio  = 0;
    m_vld    = 0;
    m_lock   = 0;
    m_mis    = 0;
    m_to     = 0;
    samp.delete();
    repeat (3) samp.push_back(1'b0);
  endtask

  // Called at each rising edge; inputs are stable here (driven on falling edges).
  task automatic model_step();
    bit rise;
    int p;
    // A meas_clk rise sampled at edge k is acted on at edge k+2.
    rise = samp[samp.size()-2] && !samp[samp.size()-3];
    samp.push_back(rst ? 1'b0 : meas_clk);
    if (samp.size() > 8) void'(samp.pop_front());
    cyc++;
    m_vld = 0;
    m_to  = 0;
    if (rst) begin
      model_reset();
    end else if (!en) begin
      m_phase = 0;
      m_match = 0;
      m_ratio = 0;
      m_lock  = 0;
      m_mis   = 0;
    end else if (m_phase == 0) begin
      m_phase  = 1;
      m_tstart = cyc;
    end else if (rise) begin
      if (m_phase == 2) begin
        p       = (cyc - m_tstart) % FULL;
        m_ratio = p;
        m_vld   = 1;
        if (p == int'(exp_ratio)) begin
          if (m_match < LK) m_match++;
          if (m_match == LK) m_lock = 1;
        end else begin
          if (m_lock) m_mis = 1;
          m_lock  = 0;
          m_match = 0;
        end
      end
      m_phase  = 2;
      m_tstart = cyc;
    end else if (((cyc - m_tstart) % FULL) == 0) begin
      m_to = 1;
      if (m_phase == 2) begin
        m_lock  = 0;
        m_match = 0;
        m_phase = 1;
      end
    end
  endtask

  task automatic gen_meas();
    int hi;
    if (div_n == 0) begin
      meas_clk = 1'b0;
    end else begin
      hi = (div_n / 2 == 0) ? 1 : div_n / 2;
      meas_clk = (ph < hi);
    end
  endtask

  task automatic set_div(input int d);
    div_n = d;
    ph    = 0;
    gen_meas();
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
    check("ratio", int'(ratio), m_ratio);
    check("ratio_vld", int'(ratio_vld), m_vld);
    check("lock", int'(lock), m_lock);
    check("mismatch", int'(mismatch), m_mis);
    check("timeout", int'(timeout), m_to);
    if (timeout) to_seen++;
    if (div_n != 0) ph = (ph + 1) % div_n;
    gen_meas();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic async_reset_pulse();
    #2 rst = 1'b1;
    #1;
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    en        = 1'b0;
    exp_ratio = '0;
    meas_clk  = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    run(3);
    check("rst_ratio", int'(ratio), 0);
    check("rst_vld", int'(ratio_vld), 0);
    check("rst_lock", int'(lock), 0);
    check("rst_mismatch", int'(mismatch), 0);
    check("rst_timeout", int'(timeout), 0);
    rst = 1'b0;

    // Divide by 5, expected 5
    set_div(5);
    exp_ratio = 8'd5;
    en        = 1'b1;
    run(60);
    check("div5_lock", int'(lock), 1);
    check("div5_ratio", int'(ratio), 5);
    check("div5_mismatch", int'(mismatch), 0);

    // Divider switched to 6 while locked
    set_div(6);
    run(40);
    check("div6_ratio", int'(ratio), 6);
    check("div6_lock", int'(lock), 0);
    check("div6_mismatch_sticky", int'(mismatch), 1);

    en = 1'b0;
    run(1);
    check("endrop_ratio", int'(ratio), 0);
    check("endrop_mismatch", int'(mismatch), 0);

    // Divide by 256 encoded as 0
    set_div(256);
    exp_ratio = 8'd0;
    en        = 1'b1;
    to_seen   = 0;
    run(7 * 256);
    check("div256_lock", int'(lock), 1);
    check("div256_ratio", int'(ratio), 0);
    check("div256_no_timeout", to_seen, 0);

    // en dropped while locked, then re-enabled
    set_div(5);
    exp_ratio = 8'd5;
    run(60);
    check("relock5_lock", int'(lock), 1);
    en = 1'b0;
    run(1);
    check("en0_lock", int'(lock), 0);
    check("en0_ratio", int'(ratio), 0);
    en = 1'b1;
    run(60);
    check("reen_lock", int'(lock), 1);

    // Stopped clock after lock: periodic timeout
    set_div(0);
    to_seen = 0;
    run(800);
    check("stop_timeouts", to_seen, 3);
    check("stop_lock", int'(lock), 0);

    // Asynchronous reset between edges while locked
    set_div(5);
    run(60);
    check("prerst_lock", int'(lock), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_lock", int'(lock), 0);
    check("arst_ratio", int'(ratio), 0);
    check("arst_mismatch", int'(mismatch), 0);
    model_reset();
    tick();
    rst = 1'b0;
    run(60);
    check("postrst_lock", int'(lock), 1);

    // Randomized segments
    for (int s = 0; s < 40; s++) begin
      int r;
      int d;
      int len;
      r = $urandom_range(0, 9);
      if (r < 5)       d = $urandom_range(2, 12);
      else if (r == 5) d = $urandom_range(250, 258);
      else if (r == 6) d = $urandom_range(0, 1);
      else             d = $urandom_range(13, 90);
      set_div(d);
      if ($urandom_range(0, 9) < 7) exp_ratio = 8'(d % FULL);
      else                          exp_ratio = 8'($urandom_range(0, 255));
      en = ($urandom_range(0, 9) != 0);
      if (d > 100)    len = $urandom_range(800, 1800);
      else if (d < 2) len = $urandom_range(300, 700);
      else            len = $urandom_range(30, 150);
      for (int k = 0; k < len; k++) begin
        if (k == len / 2 && $urandom_range(0, 3) == 0)
          exp_ratio = 8'($urandom_range(0, 255));
        tick();
      end
      if ($urandom_range(0, 9) == 0) async_reset_pulse();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
